// File: rtl/wb_tracker.sv
// wb_tracker: in-flight result tracker with in-order writeback and
// youngest-first operand forwarding for the execute stage. Each slot waits
// either on a fixed unit latency or on an external completion pulse.
module wb_tracker #(
  parameter int DEPTH = 4,
  parameter int NUNIT = 4,
  parameter int LAT_W = 6,
  parameter int XLEN  = 32,
  localparam int UW   = (NUNIT > 1) ? $clog2(NUNIT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic                  issue_wr,
  input  logic                  issue_fmode,
  input  logic [4:0]            issue_rd,
  input  logic                  issue_ext,
  input  logic [LAT_W-1:0]      issue_lat,
  input  logic [UW-1:0]         issue_unit,
  input  logic [XLEN-1:0]       issue_data,
  input  logic [NUNIT*XLEN-1:0] unit_data,
  input  logic                  ext_done,
  input  logic [XLEN-1:0]       ext_data,
  input  logic [1:0]            src_fmode,
  input  logic [9:0]            src_no,
  input  logic [2*XLEN-1:0]     src_rf,
  output logic [2*XLEN-1:0]     src_data,
  output logic                  hazard,
  output logic                  wb_valid,
  output logic                  wb_fmode,
  output logic [4:0]            wb_reg,
  output logic [XLEN-1:0]       wb_data,
  output logic                  done
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]      PTR_ONE = (PW+1)'(1);
  localparam logic [PW:0]      DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [LAT_W-1:0] CNT_ONE = LAT_W'(1);

  // Pointers run free over PW+1 bits; the low PW bits index the slot array.
  logic [PW:0]      head_reg, tail_reg, count_reg, count_next;
  logic [PW-1:0]    head_idx, tail_idx;
  logic             issue_ready_reg;

  logic             slot_valid_reg [DEPTH];
  logic             slot_wr_reg    [DEPTH];
  logic             slot_fmode_reg [DEPTH];
  logic [4:0]       slot_rd_reg    [DEPTH];
  logic             slot_ext_reg   [DEPTH];
  logic [LAT_W-1:0] slot_cnt_reg   [DEPTH];
  logic [UW-1:0]    slot_unit_reg  [DEPTH];
  logic             slot_ready_reg [DEPTH];
  logic [XLEN-1:0]  slot_data_reg  [DEPTH];

  logic [XLEN-1:0]  unit_bus [NUNIT];
  logic [XLEN-1:0]  slot_byp [DEPTH];

  logic             issue_fire, retire_fire;
  logic             ext_hit;
  logic [PW-1:0]    ext_idx;
  logic [1:0]       port_haz;

  logic             wb_valid_reg, wb_fmode_reg, done_reg;
  logic [4:0]       wb_rd_reg;
  logic [XLEN-1:0]  wb_data_reg;

  assign head_idx    = head_reg[PW-1:0];
  assign tail_idx    = tail_reg[PW-1:0];
  assign issue_fire  = issue_valid && issue_ready_reg;
  assign retire_fire = slot_valid_reg[head_idx] && slot_ready_reg[head_idx];

  assign issue_ready = issue_ready_reg;
  assign wb_valid    = wb_valid_reg;
  assign wb_fmode    = wb_fmode_reg;
  assign wb_reg      = wb_rd_reg;
  assign wb_data     = wb_data_reg;
  assign done        = done_reg;

  genvar gi;

  // Unpack the flat unit result buses.
  for (gi = 0; gi < NUNIT; gi++) begin : g_unit
    assign unit_bus[gi] = unit_data[gi*XLEN +: XLEN];
  end

  // Each slot's selected unit bus, used for capture and same-cycle bypass.
  for (gi = 0; gi < DEPTH; gi++) begin : g_byp
    assign slot_byp[gi] = unit_bus[slot_unit_reg[gi]];
  end

  // Occupancy after this cycle's issue and retire.
  always_comb begin
    count_next = count_reg;
    if (issue_fire && !retire_fire)
      count_next = count_reg + PTR_ONE;
    else if (!issue_fire && retire_fire)
      count_next = count_reg - PTR_ONE;
  end

  // Oldest valid, still-pending external slot; scanned youngest to oldest so
  // the last hit is the oldest.
  always_comb begin : ext_scan
    logic [PW-1:0] idx;
    ext_hit = 1'b0;
    ext_idx = '0;
    idx     = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      idx = head_idx + PW'(k);
      if (slot_valid_reg[idx] && slot_ext_reg[idx] && !slot_ready_reg[idx]) begin
        ext_hit = 1'b1;
        ext_idx = idx;
      end
    end
  end

  // Pointer, occupancy and registered issue_ready bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      issue_ready_reg <= 1'b1;
    end else begin
      if (issue_fire)  tail_reg <= tail_reg + PTR_ONE;
      if (retire_fire) head_reg <= head_reg + PTR_ONE;
      count_reg       <= count_next;
      issue_ready_reg <= (count_next < DEPTH_C);
    end
  end

  // Slot state: issue fill, latency countdown/capture, ext capture, retire pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_valid_reg[i] <= 1'b0;
        slot_ready_reg[i] <= 1'b0;
        slot_cnt_reg[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_valid_reg[i] && !slot_ext_reg[i] && slot_cnt_reg[i] != '0) begin
          slot_cnt_reg[i] <= slot_cnt_reg[i] - CNT_ONE;
          if (slot_cnt_reg[i] == CNT_ONE) begin
            slot_data_reg[i]  <= slot_byp[i];
            slot_ready_reg[i] <= 1'b1;
          end
        end
        if (ext_done && ext_hit && ext_idx == PW'(i)) begin
          slot_data_reg[i]  <= ext_data;
          slot_ready_reg[i] <= 1'b1;
        end
        if (retire_fire && head_idx == PW'(i))
          slot_valid_reg[i] <= 1'b0;
        // The tail slot is always empty when issue fires, so this cannot
        // collide with the updates above.
        if (issue_fire && tail_idx == PW'(i)) begin
          slot_valid_reg[i] <= 1'b1;
          slot_wr_reg[i]    <= issue_wr;
          slot_fmode_reg[i] <= issue_fmode;
          slot_rd_reg[i]    <= issue_rd;
          slot_ext_reg[i]   <= issue_ext;
          slot_unit_reg[i]  <= issue_unit;
          if (issue_ext) begin
            slot_ready_reg[i] <= 1'b0;
            slot_cnt_reg[i]   <= '0;
          end else if (issue_lat == '0) begin
            slot_ready_reg[i] <= 1'b1;
            slot_cnt_reg[i]   <= '0;
            slot_data_reg[i]  <= issue_data;
          end else begin
            slot_ready_reg[i] <= 1'b0;
            slot_cnt_reg[i]   <= issue_lat;
          end
        end
      end
    end
  end

  // Registered writeback of the retiring head slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
      wb_fmode_reg <= 1'b0;
      wb_rd_reg    <= '0;
      wb_data_reg  <= '0;
    end else begin
      done_reg     <= retire_fire;
      wb_valid_reg <= retire_fire && slot_wr_reg[head_idx];
      if (retire_fire) begin
        wb_fmode_reg <= slot_fmode_reg[head_idx];
        wb_rd_reg    <= slot_rd_reg[head_idx];
        wb_data_reg  <= slot_data_reg[head_idx];
      end
    end
  end

  // Per read port: youngest in-flight producer, then writeback, then regfile.
  for (gi = 0; gi < 2; gi++) begin : g_port
    logic            fm;
    logic [4:0]      rn;
    logic [XLEN-1:0] rf;
    logic            hit;
    logic [PW-1:0]   hit_idx;
    logic            wb_hit;
    logic [XLEN-1:0] fwd_data;
    logic            haz;

    assign fm = src_fmode[gi];
    assign rn = src_no[gi*5 +: 5];
    assign rf = src_rf[gi*XLEN +: XLEN];

    // Scan oldest to youngest; the last match is the youngest producer.
    always_comb begin : match_scan
      logic [PW-1:0] idx;
      hit     = 1'b0;
      hit_idx = '0;
      idx     = '0;
      for (int k = 0; k < DEPTH; k++) begin
        idx = head_idx + PW'(k);
        if (slot_valid_reg[idx] && slot_wr_reg[idx] && slot_fmode_reg[idx] == fm &&
            slot_rd_reg[idx] == rn && (fm || rn != 5'd0)) begin
          hit     = 1'b1;
          hit_idx = idx;
        end
      end
    end

    assign wb_hit = wb_valid_reg && wb_fmode_reg == fm && wb_rd_reg == rn &&
                    (fm || rn != 5'd0);

    // Operand select; a pending youngest producer stalls rather than
    // falling back to an older copy.
    always_comb begin
      fwd_data = rf;
      haz      = 1'b0;
      if (hit) begin
        if (slot_ready_reg[hit_idx])
          fwd_data = slot_data_reg[hit_idx];
        else if (!slot_ext_reg[hit_idx] && slot_cnt_reg[hit_idx] == CNT_ONE)
          fwd_data = slot_byp[hit_idx];
        else
          haz = 1'b1;
      end else if (wb_hit) begin
        fwd_data = wb_data_reg;
      end
    end

    assign src_data[gi*XLEN +: XLEN] = fwd_data;
    assign port_haz[gi] = haz;
  end

  assign hazard = |port_haz;

endmodule

// File: tb/tb_wb_tracker.sv
// Bench for wb_tracker: directed scenarios plus random traffic, all cycles
// checked against a queue-based timing model of the tracker.
module tb_wb_tracker;
  localparam int DEPTH = 4;
  localparam int NUNIT = 4;
  localparam int LAT_W = 6;
  localparam int XLEN  = 32;
  localparam int BIG   = 1 << 30;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  issue_valid, issue_ready, issue_wr, issue_fmode, issue_ext;
  logic [4:0]            issue_rd;
  logic [LAT_W-1:0]      issue_lat;
  logic [1:0]            issue_unit;
  logic [XLEN-1:0]       issue_data;
  logic [NUNIT*XLEN-1:0] unit_data;
  logic                  ext_done;
  logic [XLEN-1:0]       ext_data;
  logic [1:0]            src_fmode;
  logic [9:0]            src_no;
  logic [2*XLEN-1:0]     src_rf, src_data;
  logic                  hazard, wb_valid, wb_fmode, done;
  logic [4:0]            wb_reg;
  logic [XLEN-1:0]       wb_data;

  always #5 clk = ~clk;

  wb_tracker #(.DEPTH(DEPTH), .NUNIT(NUNIT), .LAT_W(LAT_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_wr(issue_wr),
    .issue_fmode(issue_fmode), .issue_rd(issue_rd), .issue_ext(issue_ext),
    .issue_lat(issue_lat), .issue_unit(issue_unit), .issue_data(issue_data),
    .unit_data(unit_data), .ext_done(ext_done), .ext_data(ext_data),
    .src_fmode(src_fmode), .src_no(src_no), .src_rf(src_rf), .src_data(src_data),
    .hazard(hazard), .wb_valid(wb_valid), .wb_fmode(wb_fmode), .wb_reg(wb_reg),
    .wb_data(wb_data), .done(done)
  );

  // Model entry: rc is the first cycle the result is ready (capture cycle + 1).
  typedef struct {
    bit          wr;
    bit          fm;
    bit [4:0]    rd;
    bit          ext;
    bit          got;
    int          lat;
    int          unit;
    int          ic;
    int          rc;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          cyc_n = 0, checks = 0, errors = 0, n_done = 0;
  bit          exp_done, exp_wbv, exp_wbf;
  logic [4:0]  exp_wbr;
  logic [31:0] exp_wbd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc_n);
    end
  endtask

  function automatic logic [31:0] ubus(input int u);
    return unit_data[u*XLEN +: XLEN];
  endfunction

  // Expected operand for one read port in the current cycle.
  function automatic void fwd(input bit fm, input bit [4:0] rn, input logic [31:0] rf,
                              output logic [31:0] d, output bit hz);
    d  = rf;
    hz = 1'b0;
    if (!fm && rn == 5'd0) return;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].wr && q[i].fm == fm && q[i].rd == rn) begin
        if (q[i].rc <= cyc_n) d = q[i].data;
        else if (!q[i].ext && q[i].lat > 0 && q[i].ic + q[i].lat == cyc_n) d = ubus(q[i].unit);
        else hz = 1'b1;
        return;
      end
    end
    if (exp_wbv && exp_wbf == fm && exp_wbr == rn) d = exp_wbd;
  endfunction

  task automatic model_check();
    logic [31:0] d0, d1;
    bit h0, h1;
    check("issue_ready", issue_ready, q.size() < DEPTH);
    check("done", done, exp_done);
    check("wb_valid", wb_valid, exp_wbv);
    if (exp_wbv) begin
      check("wb_reg", wb_reg, exp_wbr);
      check("wb_fmode", wb_fmode, exp_wbf);
      check("wb_data", wb_data, exp_wbd);
    end
    fwd(src_fmode[0], src_no[4:0], src_rf[31:0], d0, h0);
    fwd(src_fmode[1], src_no[9:5], src_rf[63:32], d1, h1);
    check("hazard", hazard, h0 | h1);
    if (!h0) check("src_data0", src_data[31:0], d0);
    if (!h1) check("src_data1", src_data[63:32], d1);
  endtask

  // Advance the model across the coming clock edge.
  task automatic model_update();
    ent_t e;
    bit full;
    if (rst) begin
      q.delete();
      exp_done = 0; exp_wbv = 0; exp_wbf = 0; exp_wbr = '0; exp_wbd = '0;
      return;
    end
    full = (q.size() >= DEPTH);
    for (int i = 0; i < q.size(); i++) begin
      if (!q[i].ext && q[i].lat > 0 && q[i].ic + q[i].lat == cyc_n) begin
        e = q[i]; e.data = ubus(e.unit); q[i] = e;
      end
    end
    if (ext_done) begin
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].ext && !q[i].got) begin
          e = q[i]; e.got = 1; e.data = ext_data; e.rc = cyc_n + 1; q[i] = e;
          break;
        end
      end
    end
    exp_done = 0;
    exp_wbv  = 0;
    if (q.size() > 0 && q[0].rc <= cyc_n) begin
      e = q.pop_front();
      exp_done = 1; exp_wbv = e.wr; exp_wbr = e.rd; exp_wbf = e.fm; exp_wbd = e.data;
      $display("retire cyc=%0d wr=%0d fm=%0d rd=%0d data=%h", cyc_n, e.wr, e.fm, e.rd, e.data);
    end
    if (issue_valid && !full) begin
      e.wr = issue_wr; e.fm = issue_fmode; e.rd = issue_rd; e.ext = issue_ext; e.got = 0;
      e.lat = int'(issue_lat); e.unit = int'(issue_unit); e.ic = cyc_n; e.data = issue_data;
      if (issue_ext) e.rc = BIG;
      else e.rc = cyc_n + e.lat + 1;
      q.push_back(e);
    end
  endtask

  task automatic set_issue(input bit wr, input bit fm, input int rd, input bit ext,
                           input int lat, input int unit, input logic [31:0] data);
    issue_valid = 1; issue_wr = wr; issue_fmode = fm; issue_rd = rd[4:0];
    issue_ext = ext; issue_lat = lat[LAT_W-1:0]; issue_unit = unit[1:0]; issue_data = data;
  endtask

  task automatic set_src(input int p, input bit fm, input int rn, input logic [31:0] rf);
    src_fmode[p] = fm;
    src_no[p*5 +: 5] = rn[4:0];
    src_rf[p*XLEN +: XLEN] = rf;
  endtask

  task automatic set_unit(input int u, input logic [31:0] d);
    unit_data[u*XLEN +: XLEN] = d;
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
    if (done === 1'b1) n_done++;
  endtask

  task automatic adv();
    model_update();
    @(posedge clk);
    #1;
    cyc_n++;
    issue_valid = 0; ext_done = 0; ext_data = '0;
    src_fmode = '0; src_no = '0; src_rf = {$urandom, $urandom};
    unit_data = '0;
  endtask

  task automatic cyc();
    settle();
    adv();
  endtask

  initial begin
    rst = 1; issue_valid = 0; issue_wr = 0; issue_fmode = 0; issue_rd = '0; issue_ext = 0;
    issue_lat = '0; issue_unit = '0; issue_data = '0; unit_data = '0; ext_done = 0;
    ext_data = '0; src_fmode = '0; src_no = '0; src_rf = '0;
    exp_done = 0; exp_wbv = 0; exp_wbf = 0; exp_wbr = '0; exp_wbd = '0;
    @(posedge clk); #1;

    // Reset state
    settle();
    check("rst_issue_ready", issue_ready, 1'b1);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wb_reg", wb_reg, 5'd0);
    check("rst_wb_fmode", wb_fmode, 1'b0);
    check("rst_wb_data", wb_data, 32'h0);
    adv();
    rst = 0;

    // Int lat=0 r3: forward at t+1, writeback at t+2
    set_issue(1, 0, 3, 0, 0, 0, 32'h11); cyc();
    set_src(0, 0, 3, 32'hdead_0003); settle();
    check("r3_fwd", src_data[31:0], 32'h11); check("r3_haz", hazard, 1'b0); adv();
    settle();
    check("r3_wbv", wb_valid, 1'b1); check("r3_wbreg", wb_reg, 5'd3);
    check("r3_wbdata", wb_data, 32'h11); check("r3_done", done, 1'b1); adv();

    // FP lat=3 unit 1 f5: stall, bypass, writeback at t+5
    set_issue(1, 1, 5, 0, 3, 1, 32'h0); cyc();
    set_src(1, 1, 5, 32'h1); settle(); check("f5_haz1", hazard, 1'b1); adv();
    set_src(1, 1, 5, 32'h1); settle(); check("f5_haz2", hazard, 1'b1); adv();
    set_src(1, 1, 5, 32'h1); set_unit(1, 32'h4040_0000); settle();
    check("f5_byp", src_data[63:32], 32'h4040_0000); check("f5_haz3", hazard, 1'b0); adv();
    cyc();
    settle();
    check("f5_wbv", wb_valid, 1'b1); check("f5_wbf", wb_fmode, 1'b1);
    check("f5_wbreg", wb_reg, 5'd5); check("f5_wbdata", wb_data, 32'h4040_0000); adv();

    // Youngest producer wins; retirement stays in order
    set_issue(1, 0, 7, 0, 4, 0, 32'h0); cyc();
    set_issue(1, 0, 7, 0, 0, 0, 32'h22); cyc();
    set_src(0, 0, 7, 32'h5); settle();
    check("r7_young", src_data[31:0], 32'h22); check("r7_haz", hazard, 1'b0); adv();
    cyc();
    set_unit(0, 32'h77); cyc();
    cyc();
    settle(); check("r7_wb_first", wb_data, 32'h77); adv();
    settle(); check("r7_wb_second", wb_data, 32'h22); check("r7_wb_reg", wb_reg, 5'd7); adv();

    // Fill all slots; extra issue ignored; ready returns the cycle after retire
    for (int i = 0; i < DEPTH; i++) begin
      set_issue(1, 0, 10 + i, 0, 5, 2, 32'h0); cyc();
    end
    set_issue(1, 0, 20, 0, 0, 0, 32'h99); settle();
    check("full_ready", issue_ready, 1'b0); adv();
    cyc();
    settle(); check("full_ready_retire", issue_ready, 1'b0); adv();
    settle(); check("full_ready_after", issue_ready, 1'b1); adv();
    repeat (8) cyc();

    // Back-to-back issues wrap the pointers three times
    n_done = 0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      set_issue(1, i[0], 8 + i, 0, 1, i % 4, 32'h0);
      for (int u = 0; u < NUNIT; u++) set_unit(u, $urandom);
      cyc();
    end
    repeat (6) begin
      for (int u = 0; u < NUNIT; u++) set_unit(u, $urandom);
      cyc();
    end
    check("wrap_done_count", n_done, 3 * DEPTH);

    // External completions pair oldest-first; stray ext_done ignored
    set_issue(1, 0, 2, 1, 0, 0, 32'h0); cyc();
    set_issue(0, 0, 9, 1, 0, 0, 32'h0); cyc();
    set_src(0, 0, 2, 32'h3); settle(); check("ext_haz", hazard, 1'b1); adv();
    ext_done = 1; ext_data = 32'hAB; cyc();
    set_src(0, 0, 2, 32'h3); settle();
    check("ext_fwd", src_data[31:0], 32'hAB); check("ext_haz_clr", hazard, 1'b0); adv();
    settle();
    check("ext_wbv", wb_valid, 1'b1); check("ext_wbreg", wb_reg, 5'd2);
    check("ext_wbdata", wb_data, 32'hAB); adv();
    ext_done = 1; ext_data = 32'hCD; cyc();
    cyc();
    settle(); check("ext2_done", done, 1'b1); check("ext2_wbv", wb_valid, 1'b0); adv();
    ext_done = 1; ext_data = 32'hEE; cyc();
    settle(); check("stray_done", done, 1'b0); adv();
    set_issue(1, 0, 4, 1, 0, 0, 32'h0); cyc();
    set_src(0, 0, 4, 32'h4); settle(); check("stray_ignored", hazard, 1'b1); adv();
    ext_done = 1; ext_data = 32'h44; cyc();
    repeat (3) cyc();

    // Integer r0 never forwards
    set_issue(1, 0, 0, 0, 0, 0, 32'h55); cyc();
    set_src(0, 0, 0, 32'h1234); settle();
    check("r0_rf", src_data[31:0], 32'h1234); check("r0_haz", hazard, 1'b0); adv();
    set_src(0, 0, 0, 32'h5678); settle();
    check("r0_wbv", wb_valid, 1'b1); check("r0_rf_wb", src_data[31:0], 32'h5678); adv();

    // Reset with three slots busy discards them
    for (int i = 0; i < 3; i++) begin
      set_issue(1, 0, 12 + i, 0, 10, 0, 32'h0); cyc();
    end
    rst = 1; cyc(); rst = 0;
    for (int i = 0; i < 16; i++) begin
      settle();
      check("post_rst_wbv", wb_valid, 1'b0); check("post_rst_done", done, 1'b0);
      check("post_rst_ready", issue_ready, 1'b1);
      adv();
    end

    // Random traffic against the model
    repeat (500) begin
      if ($urandom_range(0, 9) < 6)
        set_issue($urandom_range(0, 7) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 6), $urandom_range(0, 3), $urandom);
      ext_done = ($urandom_range(0, 3) == 0);
      ext_data = $urandom;
      for (int p = 0; p < 2; p++)
        set_src(p, $urandom_range(0, 1) != 0, $urandom_range(0, 7), $urandom);
      for (int u = 0; u < NUNIT; u++) set_unit(u, $urandom);
      cyc();
    end
    repeat (40) begin
      ext_done = 1; ext_data = $urandom;
      for (int u = 0; u < NUNIT; u++) set_unit(u, $urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
